mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store memory bus arbiter, one bus transaction outstanding
//
// Purpose: merges the IFU fetch port and the LSU access port onto one request/ack,
// response-valid memory bus. Each requester has a single-entry command latch. While
// both requesters want the bus, grants alternate.
//
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   i_ifu_addr, i_ifu_rd       fetch command (one-cycle pulse, word aligned)
//   o_ifu_busy                 fetch outstanding
//   o_ifu_rdat                 last fetched word
//   o_ifu_err_align            one-cycle pulse for a misaligned fetch
//   o_ifu_err_bus              one-cycle pulse for a fetch bus error
//   i_lsu_addr, i_lsu_cmd      load/store command (one-cycle pulse)
//   i_lsu_rnw, i_lsu_wdat      direction and write data
//   i_lsu_be                   byte enables
//   o_lsu_busy                 access outstanding
//   o_lsu_rdat                 last read data
//   o_lsu_err_bus              one-cycle pulse for a bus error
//   o_bus_req, o_bus_addr      bus command valid and address
//   o_bus_wdat, o_bus_be       bus write data and byte enables
//   o_bus_rnw                  bus direction
//   i_bus_ack                  command accepted
//   i_bus_rsp_valid            response valid
//   i_bus_rsp_err, i_bus_rdat  response error flag and read data
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_addr,
  input  logic                    i_ifu_rd,
  output logic                    o_ifu_busy,
  output logic [DATA_WIDTH-1:0]   o_ifu_rdat,
  output logic                    o_ifu_err_align,
  output logic                    o_ifu_err_bus,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
  input  logic                    i_lsu_cmd,
  input  logic                    i_lsu_rnw,
  input  logic [DATA_WIDTH-1:0]   i_lsu_wdat,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_be,
  output logic                    o_lsu_busy,
  output logic [DATA_WIDTH-1:0]   o_lsu_rdat,
  output logic                    o_lsu_err_bus,
  output logic [ADDR_WIDTH-1:0]   o_bus_addr,
  output logic [DATA_WIDTH-1:0]   o_bus_wdat,
  output logic [DATA_WIDTH/8-1:0] o_bus_be,
  output logic                    o_bus_rnw,
  output logic                    o_bus_req,
  input  logic                    i_bus_ack,
  input  logic                    i_bus_rsp_valid,
  input  logic                    i_bus_rsp_err,
  input  logic [DATA_WIDTH-1:0]   i_bus_rdat
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    IFU_REQ,
    IFU_RSP,
    LSU_REQ,
    LSU_RSP
  } state_t;

  state_t state, state_nx;

  logic                  ifu_pend;
  logic [ADDR_WIDTH-1:0] ifu_addr_q;
  logic                  lsu_pend;
  logic [ADDR_WIDTH-1:0] lsu_addr_q;
  logic                  lsu_rnw_q;
  logic [DATA_WIDTH-1:0] lsu_wdat_q;
  logic [BE_WIDTH-1:0]   lsu_be_q;
  logic                  last_lsu;   // 1 when the LSU received the most recent grant

  logic ifu_misalign;
  logic ifu_accept;
  logic lsu_accept;
  logic ifu_want;
  logic lsu_want;
  logic grant_lsu;
  logic arb_now;

  // A pulse from a requester that is already pending is dropped outright,
  // including a misaligned one (no alignment error for a dropped pulse).
  assign ifu_misalign = (i_ifu_addr[1:0] != 2'b00);
  assign ifu_accept   = i_ifu_rd & ~ifu_pend & ~ifu_misalign;
  assign lsu_accept   = i_lsu_cmd & ~lsu_pend;

  // Arbitration sees a pulse on the same edge it is latched, so an idle
  // arbiter raises o_bus_req the cycle after the pulse.
  assign ifu_want  = ifu_pend | ifu_accept;
  assign lsu_want  = lsu_pend | lsu_accept;
  assign grant_lsu = lsu_want & (~ifu_want | ~last_lsu);
  assign arb_now   = (state == IDLE) & (ifu_want | lsu_want);

  assign o_ifu_busy = ifu_pend;
  assign o_lsu_busy = lsu_pend;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    o_bus_req  = 1'b0;
    o_bus_addr = '0;
    o_bus_wdat = '0;
    o_bus_be   = '0;
    o_bus_rnw  = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_want | lsu_want) begin
          state_nx = grant_lsu ? LSU_REQ : IFU_REQ;
        end
      end
      IFU_REQ: begin
        o_bus_req  = 1'b1;
        o_bus_addr = ifu_addr_q;
        o_bus_be   = '1;
        o_bus_rnw  = 1'b1;
        if (i_bus_ack) begin
          state_nx = IFU_RSP;
        end
      end
      IFU_RSP: begin
        if (i_bus_rsp_valid) begin
          state_nx = IDLE;
        end
      end
      LSU_REQ: begin
        o_bus_req  = 1'b1;
        o_bus_addr = lsu_addr_q;
        o_bus_wdat = lsu_wdat_q;
        o_bus_be   = lsu_be_q;
        o_bus_rnw  = lsu_rnw_q;
        if (i_bus_ack) begin
          state_nx = LSU_RSP;
        end
      end
      LSU_RSP: begin
        if (i_bus_rsp_valid) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ifu_pend        <= 1'b0;
      ifu_addr_q      <= '0;
      lsu_pend        <= 1'b0;
      lsu_addr_q      <= '0;
      lsu_rnw_q       <= 1'b0;
      lsu_wdat_q      <= '0;
      lsu_be_q        <= '0;
      last_lsu        <= 1'b0;
      o_ifu_rdat      <= '0;
      o_lsu_rdat      <= '0;
      o_ifu_err_align <= 1'b0;
      o_ifu_err_bus   <= 1'b0;
      o_lsu_err_bus   <= 1'b0;
    end else begin
      o_ifu_err_align <= i_ifu_rd & ~ifu_pend & ifu_misalign;
      o_ifu_err_bus   <= 1'b0;
      o_lsu_err_bus   <= 1'b0;

      if (ifu_accept) begin
        ifu_pend   <= 1'b1;
        ifu_addr_q <= i_ifu_addr;
      end
      if (lsu_accept) begin
        lsu_pend   <= 1'b1;
        lsu_addr_q <= i_lsu_addr;
        lsu_rnw_q  <= i_lsu_rnw;
        lsu_wdat_q <= i_lsu_wdat;
        lsu_be_q   <= i_lsu_be;
      end

      if (arb_now) begin
        last_lsu <= grant_lsu;
      end

      // Completion never coincides with an accept for the same requester:
      // the requester is pending throughout its own transaction.
      if ((state == IFU_RSP) && i_bus_rsp_valid) begin
        ifu_pend      <= 1'b0;
        o_ifu_rdat    <= i_bus_rsp_err ? '0 : i_bus_rdat;
        o_ifu_err_bus <= i_bus_rsp_err;
      end
      if ((state == LSU_RSP) && i_bus_rsp_valid) begin
        lsu_pend      <= 1'b0;
        o_lsu_err_bus <= i_bus_rsp_err;
        if (lsu_rnw_q) begin
          o_lsu_rdat <= i_bus_rsp_err ? '0 : i_bus_rdat;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk;
  logic        nrst;
  logic [31:0] i_ifu_addr;
  logic        i_ifu_rd;
  logic        o_ifu_busy;
  logic [31:0] o_ifu_rdat;
  logic        o_ifu_err_align;
  logic        o_ifu_err_bus;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_cmd;
  logic        i_lsu_rnw;
  logic [31:0] i_lsu_wdat;
  logic [3:0]  i_lsu_be;
  logic        o_lsu_busy;
  logic [31:0] o_lsu_rdat;
  logic        o_lsu_err_bus;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdat;
  logic [3:0]  o_bus_be;
  logic        o_bus_rnw;
  logic        o_bus_req;
  logic        i_bus_ack;
  logic        i_bus_rsp_valid;
  logic        i_bus_rsp_err;
  logic [31:0] i_bus_rdat;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .i_ifu_addr      (i_ifu_addr),
    .i_ifu_rd        (i_ifu_rd),
    .o_ifu_busy      (o_ifu_busy),
    .o_ifu_rdat      (o_ifu_rdat),
    .o_ifu_err_align (o_ifu_err_align),
    .o_ifu_err_bus   (o_ifu_err_bus),
    .i_lsu_addr      (i_lsu_addr),
    .i_lsu_cmd       (i_lsu_cmd),
    .i_lsu_rnw       (i_lsu_rnw),
    .i_lsu_wdat      (i_lsu_wdat),
    .i_lsu_be        (i_lsu_be),
    .o_lsu_busy      (o_lsu_busy),
    .o_lsu_rdat      (o_lsu_rdat),
    .o_lsu_err_bus   (o_lsu_err_bus),
    .o_bus_addr      (o_bus_addr),
    .o_bus_wdat      (o_bus_wdat),
    .o_bus_be        (o_bus_be),
    .o_bus_rnw       (o_bus_rnw),
    .o_bus_req       (o_bus_req),
    .i_bus_ack       (i_bus_ack),
    .i_bus_rsp_valid (i_bus_rsp_valid),
    .i_bus_rsp_err   (i_bus_rsp_err),
    .i_bus_rdat      (i_bus_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        ifu_rd;
    logic [31:0] ifu_addr;
    logic        lsu_cmd;
    logic        lsu_rnw;
    logic [31:0] lsu_addr;
    logic        ack;
    logic        rsp_v;
    logic        rsp_err;
    logic [31:0] rdat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifu_busy;
    logic        e_lsu_busy;
    logic [31:0] e_ifu_rdat;
    logic [31:0] e_lsu_rdat;
    logic        e_align;
    logic        e_ifu_err;
    logic        e_lsu_err;
  } vec_t;

  vec_t vt[14];

  // Reference model state (transaction level)
  logic        m_ifu_out;
  logic [31:0] m_ifu_addr;
  logic        m_lsu_out;
  logic [31:0] m_lsu_addr;
  logic [31:0] m_lsu_wdat;
  logic [3:0]  m_lsu_be;
  logic        m_lsu_rnw;
  int          m_owner;   // 0 none, 1 IFU, 2 LSU
  int          m_last;    // requester granted most recently
  logic        m_acked;
  logic        m_gap;
  logic [31:0] m_ifu_rdat;
  logic [31:0] m_lsu_rdat;
  logic        m_align;
  logic        m_ifu_err;
  logic        m_lsu_err;
  logic        exp_req;
  logic        acc_i;
  logic        acc_l;
  logic [31:0] e_addr;
  logic [31:0] e_wdat;
  logic [3:0]  e_be;
  logic        e_rnw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    i_ifu_rd        = 1'b0;
    i_lsu_cmd       = 1'b0;
    i_bus_ack       = 1'b0;
    i_bus_rsp_valid = 1'b0;
    i_bus_rsp_err   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, o_bus_req, 0);
    chk({tag, "_addr"}, o_bus_addr, 0);
    chk({tag, "_wdat"}, o_bus_wdat, 0);
    chk({tag, "_be"}, o_bus_be, 0);
    chk({tag, "_rnw"}, o_bus_rnw, 0);
    chk({tag, "_ifu_busy"}, o_ifu_busy, 0);
    chk({tag, "_lsu_busy"}, o_lsu_busy, 0);
    chk({tag, "_ifu_rdat"}, o_ifu_rdat, 0);
    chk({tag, "_lsu_rdat"}, o_lsu_rdat, 0);
    chk({tag, "_errs"}, {o_ifu_err_align, o_ifu_err_bus, o_lsu_err_bus}, 0);
  endtask

  task automatic do_reset();
    clr_in();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    nrst = 1'b1;
  endtask

  initial begin
    i_ifu_addr = '0; i_lsu_addr = '0; i_lsu_rnw = 1'b0;
    i_lsu_wdat = '0; i_lsu_be = '0; i_bus_rdat = '0;
    clr_in();
    nrst = 1'b0;

    //            ifu_rd addr        lsu rnw lsu_addr     ack rsp err rdat           req addr        ib lb ifu_rdat       lsu_rdat       al ie le
    vt[0]  = '{T, 32'h100, F, F, 32'h0,   F, F, F, 32'h0,        T, 32'h100, T, F, 32'h0,        32'h0,        F, F, F};
    vt[1]  = '{F, 32'h0,   F, F, 32'h0,   T, F, F, 32'h0,        F, 32'h0,   T, F, 32'h0,        32'h0,        F, F, F};
    vt[2]  = '{F, 32'h0,   F, F, 32'h0,   F, T, F, 32'hDEADBEEF, F, 32'h0,   F, F, 32'hDEADBEEF, 32'h0,        F, F, F};
    vt[3]  = '{F, 32'h0,   F, F, 32'h0,   F, F, F, 32'h0,        F, 32'h0,   F, F, 32'hDEADBEEF, 32'h0,        F, F, F};
    vt[4]  = '{T, 32'h102, F, F, 32'h0,   F, F, F, 32'h0,        F, 32'h0,   F, F, 32'hDEADBEEF, 32'h0,        T, F, F};
    vt[5]  = '{F, 32'h0,   F, F, 32'h0,   F, F, F, 32'h0,        F, 32'h0,   F, F, 32'hDEADBEEF, 32'h0,        F, F, F};
    vt[6]  = '{F, 32'h0,   F, F, 32'h0,   T, T, F, 32'h12345678, F, 32'h0,   F, F, 32'hDEADBEEF, 32'h0,        F, F, F};
    vt[7]  = '{F, 32'h0,   T, T, 32'h200, F, F, F, 32'h0,        T, 32'h200, F, T, 32'hDEADBEEF, 32'h0,        F, F, F};
    vt[8]  = '{F, 32'h0,   F, F, 32'h0,   T, F, F, 32'h0,        F, 32'h0,   F, T, 32'hDEADBEEF, 32'h0,        F, F, F};
    vt[9]  = '{F, 32'h0,   F, F, 32'h0,   F, T, F, 32'hCAFEF00D, F, 32'h0,   F, F, 32'hDEADBEEF, 32'hCAFEF00D, F, F, F};
    vt[10] = '{F, 32'h0,   T, T, 32'h204, F, F, F, 32'h0,        T, 32'h204, F, T, 32'hDEADBEEF, 32'hCAFEF00D, F, F, F};
    vt[11] = '{F, 32'h0,   F, F, 32'h0,   T, F, F, 32'h0,        F, 32'h0,   F, T, 32'hDEADBEEF, 32'hCAFEF00D, F, F, F};
    vt[12] = '{F, 32'h0,   F, F, 32'h0,   F, T, T, 32'hAAAA5555, F, 32'h0,   F, F, 32'hDEADBEEF, 32'h0,        F, F, T};
    vt[13] = '{F, 32'h0,   F, F, 32'h0,   F, F, F, 32'h0,        F, 32'h0,   F, F, 32'hDEADBEEF, 32'h0,        F, F, F};

    @(negedge clk);
    do_reset();

    // Table-driven single-requester traffic
    for (int i = 0; i < 14; i++) begin
      i_ifu_rd = vt[i].ifu_rd; i_ifu_addr = vt[i].ifu_addr;
      i_lsu_cmd = vt[i].lsu_cmd; i_lsu_rnw = vt[i].lsu_rnw; i_lsu_addr = vt[i].lsu_addr;
      i_lsu_wdat = '0; i_lsu_be = 4'hF;
      i_bus_ack = vt[i].ack; i_bus_rsp_valid = vt[i].rsp_v;
      i_bus_rsp_err = vt[i].rsp_err; i_bus_rdat = vt[i].rdat;
      tick();
      chk($sformatf("vec%0d_req", i), o_bus_req, vt[i].e_req);
      chk($sformatf("vec%0d_addr", i), o_bus_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_ifu_busy", i), o_ifu_busy, vt[i].e_ifu_busy);
      chk($sformatf("vec%0d_lsu_busy", i), o_lsu_busy, vt[i].e_lsu_busy);
      chk($sformatf("vec%0d_ifu_rdat", i), o_ifu_rdat, vt[i].e_ifu_rdat);
      chk($sformatf("vec%0d_lsu_rdat", i), o_lsu_rdat, vt[i].e_lsu_rdat);
      chk($sformatf("vec%0d_align", i), o_ifu_err_align, vt[i].e_align);
      chk($sformatf("vec%0d_ifu_err", i), o_ifu_err_bus, vt[i].e_ifu_err);
      chk($sformatf("vec%0d_lsu_err", i), o_lsu_err_bus, vt[i].e_lsu_err);
    end
    clr_in();

    // Contention: LSU wins first, then IFU wins a second contention
    do_reset();
    i_ifu_rd = 1'b1; i_ifu_addr = 32'h300;
    i_lsu_cmd = 1'b1; i_lsu_rnw = 1'b0; i_lsu_addr = 32'h400; i_lsu_wdat = 32'h11223344; i_lsu_be = 4'hF;
    tick(); clr_in();
    chk("con1_req", o_bus_req, 1);
    chk("con1_addr", o_bus_addr, 32'h400);
    chk("con1_rnw", o_bus_rnw, 0);
    chk("con1_wdat", o_bus_wdat, 32'h11223344);
    chk("con1_both_busy", {o_ifu_busy, o_lsu_busy}, 2'b11);
    i_bus_ack = 1'b1; tick(); clr_in();
    chk("con1_after_ack_req", o_bus_req, 0);
    i_bus_rsp_valid = 1'b1; tick(); clr_in();
    chk("con1_gap_req", o_bus_req, 0);
    chk("con1_busy", {o_ifu_busy, o_lsu_busy}, 2'b10);
    i_lsu_cmd = 1'b1; i_lsu_rnw = 1'b1; i_lsu_addr = 32'h500;
    tick(); clr_in();
    chk("con2_req", o_bus_req, 1);
    chk("con2_grant_ifu_addr", o_bus_addr, 32'h300);
    chk("con2_rnw", o_bus_rnw, 1);
    chk("con2_be", o_bus_be, 4'hF);
    chk("con2_lsu_busy", o_lsu_busy, 1);
    i_bus_ack = 1'b1; tick(); clr_in();
    i_bus_rsp_valid = 1'b1; i_bus_rdat = 32'h0BADF00D; tick(); clr_in();
    chk("con2_ifu_rdat", o_ifu_rdat, 32'h0BADF00D);
    chk("con2_gap_req", o_bus_req, 0);
    tick();
    chk("con3_req", o_bus_req, 1);
    chk("con3_addr", o_bus_addr, 32'h500);
    i_bus_ack = 1'b1; tick(); clr_in();
    i_bus_rsp_valid = 1'b1; i_bus_rdat = 32'h55667788; tick(); clr_in();
    chk("con3_lsu_rdat", o_lsu_rdat, 32'h55667788);

    // LSU write, ack delayed three cycles, error response
    i_lsu_cmd = 1'b1; i_lsu_rnw = 1'b0; i_lsu_addr = 32'h600; i_lsu_wdat = 32'hA5A5A5A5; i_lsu_be = 4'b0011;
    tick(); clr_in();
    for (int k = 0; k < 4; k++) begin
      chk("wr_req", o_bus_req, 1);
      chk("wr_addr", o_bus_addr, 32'h600);
      chk("wr_wdat", o_bus_wdat, 32'hA5A5A5A5);
      chk("wr_be", o_bus_be, 4'b0011);
      chk("wr_rnw", o_bus_rnw, 0);
      i_lsu_addr = $urandom; i_lsu_wdat = $urandom; i_lsu_be = 4'b1100;
      if (k == 3) i_bus_ack = 1'b1;
      tick(); clr_in();
    end
    chk("wr_after_ack_req", o_bus_req, 0);
    i_bus_rsp_valid = 1'b1; i_bus_rsp_err = 1'b1; i_bus_rdat = 32'hFFFFFFFF;
    tick(); clr_in();
    chk("wr_err_pulse", o_lsu_err_bus, 1);
    chk("wr_rdat_held", o_lsu_rdat, 32'h55667788);
    chk("wr_busy_clear", o_lsu_busy, 0);
    tick();
    chk("wr_err_one_cycle", o_lsu_err_bus, 0);

    // Reset during IFU_RSP; late response must be ignored
    i_ifu_rd = 1'b1; i_ifu_addr = 32'h700; tick(); clr_in();
    i_bus_ack = 1'b1; tick(); clr_in();
    chk("rst_busy_before", o_ifu_busy, 1);
    nrst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk); @(negedge clk);
    nrst = 1'b1;
    i_bus_rsp_valid = 1'b1; i_bus_rdat = 32'h99999999; tick(); clr_in();
    chk("rst_late_busy", o_ifu_busy, 0);
    chk("rst_late_rdat", o_ifu_rdat, 0);
    chk("rst_late_err", o_ifu_err_bus, 0);
    chk("rst_late_req", o_bus_req, 0);
    i_ifu_rd = 1'b1; i_ifu_addr = 32'h704; tick(); clr_in();
    chk("rst_next_req", o_bus_req, 1);
    chk("rst_next_addr", o_bus_addr, 32'h704);
    i_bus_ack = 1'b1; tick(); clr_in();
    i_bus_rsp_valid = 1'b1; i_bus_rdat = 32'h13579BDF; tick(); clr_in();
    chk("rst_next_rdat", o_ifu_rdat, 32'h13579BDF);
    chk("rst_next_busy", o_ifu_busy, 0);

    // Randomized traffic against the transaction-level model
    do_reset();
    m_ifu_out = 0; m_lsu_out = 0; m_ifu_addr = 0; m_lsu_addr = 0; m_lsu_wdat = 0;
    m_lsu_be = 0; m_lsu_rnw = 0; m_owner = 0; m_last = 1; m_acked = 0; m_gap = 0;
    m_ifu_rdat = 0; m_lsu_rdat = 0; m_align = 0; m_ifu_err = 0; m_lsu_err = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd_ifu_busy", o_ifu_busy, m_ifu_out);
      chk("rnd_lsu_busy", o_lsu_busy, m_lsu_out);
      chk("rnd_ifu_rdat", o_ifu_rdat, m_ifu_rdat);
      chk("rnd_lsu_rdat", o_lsu_rdat, m_lsu_rdat);
      chk("rnd_align", o_ifu_err_align, m_align);
      chk("rnd_ifu_err", o_ifu_err_bus, m_ifu_err);
      chk("rnd_lsu_err", o_lsu_err_bus, m_lsu_err);
      if (m_owner == 0) begin
        exp_req = !m_gap && (m_ifu_out || m_lsu_out);
        if (exp_req && o_bus_req) begin
          if (m_ifu_out && m_lsu_out) m_owner = (m_last == 1) ? 2 : 1;
          else m_owner = m_ifu_out ? 1 : 2;
          m_last = m_owner;
          m_acked = 0;
        end
      end else begin
        exp_req = !m_acked;
      end
      m_gap = 0;
      e_addr = 0; e_wdat = 0; e_be = 0; e_rnw = 0;
      if (m_owner == 1 && !m_acked) begin
        e_addr = m_ifu_addr; e_be = 4'hF; e_rnw = 1;
      end else if (m_owner == 2 && !m_acked) begin
        e_addr = m_lsu_addr; e_wdat = m_lsu_wdat; e_be = m_lsu_be; e_rnw = m_lsu_rnw;
      end
      chk("rnd_req", o_bus_req, exp_req);
      chk("rnd_addr", o_bus_addr, e_addr);
      chk("rnd_wdat", o_bus_wdat, e_wdat);
      chk("rnd_be", o_bus_be, e_be);
      chk("rnd_rnw", o_bus_rnw, e_rnw);

      i_ifu_rd = ($urandom_range(0, 4) == 0);
      i_ifu_addr = $urandom;
      if ($urandom_range(0, 3) != 0) i_ifu_addr[1:0] = 2'b00;
      i_lsu_cmd = ($urandom_range(0, 4) == 0);
      i_lsu_rnw = $urandom_range(0, 1);
      i_lsu_addr = $urandom; i_lsu_wdat = $urandom; i_lsu_be = 4'($urandom);
      if (m_owner != 0 && !m_acked) i_bus_ack = $urandom_range(0, 1);
      else i_bus_ack = ($urandom_range(0, 7) == 0);
      if (m_owner != 0 && m_acked) i_bus_rsp_valid = ($urandom_range(0, 2) == 0);
      else i_bus_rsp_valid = ($urandom_range(0, 7) == 0);
      i_bus_rsp_err = ($urandom_range(0, 3) == 0);
      i_bus_rdat = $urandom;

      acc_i = i_ifu_rd && !m_ifu_out && (i_ifu_addr[1:0] == 2'b00);
      acc_l = i_lsu_cmd && !m_lsu_out;
      m_align = i_ifu_rd && !m_ifu_out && (i_ifu_addr[1:0] != 2'b00);
      m_ifu_err = 0; m_lsu_err = 0;
      if (m_owner != 0 && !m_acked && i_bus_ack) begin
        m_acked = 1;
      end else if (m_owner != 0 && m_acked && i_bus_rsp_valid) begin
        if (m_owner == 1) begin
          m_ifu_out = 0;
          m_ifu_rdat = i_bus_rsp_err ? 32'h0 : i_bus_rdat;
          m_ifu_err = i_bus_rsp_err;
        end else begin
          m_lsu_out = 0;
          if (m_lsu_rnw) m_lsu_rdat = i_bus_rsp_err ? 32'h0 : i_bus_rdat;
          m_lsu_err = i_bus_rsp_err;
        end
        m_owner = 0;
        m_gap = 1;
      end
      if (acc_i) begin
        m_ifu_out = 1; m_ifu_addr = i_ifu_addr;
      end
      if (acc_l) begin
        m_lsu_out = 1; m_lsu_addr = i_lsu_addr; m_lsu_wdat = i_lsu_wdat;
        m_lsu_be = i_lsu_be; m_lsu_rnw = i_lsu_rnw;
      end
      tick();
    end
    clr_in();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
